// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg
//   Shared definitions for the gpio_irq block: register index constants and
//   helpers that split the 5-bit WISHBONE address into register index and
//   byte lane.
//   No ports (package).
package gpio_irq_pkg;

    localparam logic [2:0] GPIO_DIR  = 3'd0;
    localparam logic [2:0] GPIO_OUT  = 3'd1;
    localparam logic [2:0] GPIO_IN   = 3'd2;
    localparam logic [2:0] GPIO_IE   = 3'd3;
    localparam logic [2:0] GPIO_RISE = 3'd4;
    localparam logic [2:0] GPIO_FALL = 3'd5;
    localparam logic [2:0] GPIO_ISR  = 3'd6;

    // adr = {reg[2:0], byte[1:0]}
    function automatic logic [2:0] adr_reg(input logic [4:0] adr);
        return adr[4:2];
    endfunction

    function automatic logic [1:0] adr_lane(input logic [4:0] adr);
        return adr[1:0];
    endfunction

endpackage

// File: rtl/gpio_irq_sync_edge.sv
// gpio_sync_edge
//   Two-flop synchroniser for a vector of asynchronous pad inputs, followed by
//   a one-cycle history register used for edge detection.
//   Ports:
//     clk_i  system clock
//     rst_i  asynchronous reset, active-low
//     d      asynchronous pad inputs
//     sync   synchronised level (second flop)
//     rise   one-cycle pulse on a synchronised 0->1 transition
//     fall   one-cycle pulse on a synchronised 1->0 transition
module gpio_sync_edge #(
    parameter int IO = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [IO-1:0] d,
    output logic [IO-1:0] sync,
    output logic [IO-1:0] rise,
    output logic [IO-1:0] fall
);

    logic [IO-1:0] sync1;
    logic [IO-1:0] sync2;
    logic [IO-1:0] prev;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync = sync2;
    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq
//   WISHBONE GPIO controller with an 8-bit data bus and IO pins. Per-pin
//   direction, output level, synchronised input readback and edge-detect
//   interrupts (rising/falling enables, W1C status, interrupt enable) that
//   combine into one registered level interrupt.
//   Ports:
//     clk_i    system clock
//     rst_i    asynchronous reset, active-low
//     cyc_i    WISHBONE cycle
//     stb_i    WISHBONE strobe
//     adr_i    {reg[2:0], byte[1:0]}
//     we_i     write enable
//     dat_i    write data
//     dat_o    read data, valid while ack_o=1
//     ack_o    single-cycle registered acknowledge
//     gpio_i   pad inputs (asynchronous)
//     gpio_o   pad output levels
//     gpio_oe  pad output enables
//     irq_o    registered level interrupt
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int IO = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic [4:0]    adr_i,
    input  logic          we_i,
    input  logic [7:0]    dat_i,
    output logic [7:0]    dat_o,
    output logic          ack_o,
    input  logic [IO-1:0] gpio_i,
    output logic [IO-1:0] gpio_o,
    output logic [IO-1:0] gpio_oe,
    output logic          irq_o
);

    logic [IO-1:0] dir_q;
    logic [IO-1:0] out_q;
    logic [IO-1:0] ie_q;
    logic [IO-1:0] rise_en_q;
    logic [IO-1:0] fall_en_q;
    logic [IO-1:0] isr_q;

    logic [IO-1:0] pin_sync;
    logic [IO-1:0] pin_rise;
    logic [IO-1:0] pin_fall;

    logic          acc;
    logic          wr;
    logic [2:0]    reg_sel;
    logic [1:0]    lane;
    logic [IO-1:0] lane_mask;
    logic [IO-1:0] wdata;
    logic [IO-1:0] wbits;
    logic [IO-1:0] isr_clr;
    logic [IO-1:0] isr_set;
    logic [31:0]   rd_full;
    logic [7:0]    rd_byte;

    gpio_sync_edge #(.IO(IO)) u_sync_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (gpio_i),
        .sync  (pin_sync),
        .rise  (pin_rise),
        .fall  (pin_fall)
    );

    // ack_o masks the access term so a strobe held through the ack cycle
    // does not start a second (repeated) access on that edge.
    assign acc     = cyc_i & stb_i & ~ack_o;
    assign wr      = acc & we_i;
    assign reg_sel = adr_reg(adr_i);
    assign lane    = adr_lane(adr_i);

    // Only pins that exist get a lane bit, so upper lanes never write.
    genvar g;
    generate
        for (g = 0; g < IO; g++) begin : g_lane
            assign lane_mask[g] = (lane == 2'(g / 8));
            assign wdata[g]     = dat_i[g % 8];
        end
    endgenerate

    assign wbits   = wdata & lane_mask;
    assign isr_clr = (wr && reg_sel == GPIO_ISR) ? wbits : '0;
    assign isr_set = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

    always_comb begin
        rd_full = '0;
        rd_byte = 8'h00;
        case (reg_sel)
            GPIO_DIR:  rd_full[IO-1:0] = dir_q;
            GPIO_OUT:  rd_full[IO-1:0] = out_q;
            GPIO_IN:   rd_full[IO-1:0] = pin_sync;
            GPIO_IE:   rd_full[IO-1:0] = ie_q;
            GPIO_RISE: rd_full[IO-1:0] = rise_en_q;
            GPIO_FALL: rd_full[IO-1:0] = fall_en_q;
            GPIO_ISR:  rd_full[IO-1:0] = isr_q;
            default:   rd_full = '0;
        endcase
        case (lane)
            2'd0:    rd_byte = rd_full[7:0];
            2'd1:    rd_byte = rd_full[15:8];
            2'd2:    rd_byte = rd_full[23:16];
            default: rd_byte = rd_full[31:24];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dir_q     <= '0;
            out_q     <= '0;
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            isr_q     <= '0;
            dat_o     <= 8'h00;
            ack_o     <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            ack_o <= acc;
            if (acc) begin
                dat_o <= rd_byte;
            end
            if (wr) begin
                case (reg_sel)
                    GPIO_DIR:  dir_q     <= (dir_q & ~lane_mask) | wbits;
                    GPIO_OUT:  out_q     <= (out_q & ~lane_mask) | wbits;
                    GPIO_IE:   ie_q      <= (ie_q & ~lane_mask) | wbits;
                    GPIO_RISE: rise_en_q <= (rise_en_q & ~lane_mask) | wbits;
                    GPIO_FALL: fall_en_q <= (fall_en_q & ~lane_mask) | wbits;
                    default:   ;
                endcase
            end
            // Clear first, then set: a new edge survives a simultaneous W1C.
            isr_q <= (isr_q & ~isr_clr) | isr_set;
            irq_o <= |(isr_q & ie_q);
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;

    localparam int          IO     = 16;
    localparam logic [31:0] IOMASK = 32'h0000_FFFF;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic [4:0]    adr_i = '0;
    logic          we_i  = 1'b0;
    logic [7:0]    dat_i = '0;
    logic [7:0]    dat_o;
    logic          ack_o;
    logic [IO-1:0] gpio_i = '0;
    logic [IO-1:0] gpio_o;
    logic [IO-1:0] gpio_oe;
    logic          irq_o;

    int n_cmp = 0;
    int n_mis = 0;

    gpio_irq #(.IO(IO)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .adr_i   (adr_i),
        .we_i    (we_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Register file as plain 32-bit words; pin history h[0..2] holds the pad
    // value seen 1, 2 and 3 clock edges ago. IN shows the 2-edge-old sample,
    // an edge is a difference between the 2- and 3-edge-old samples.
    logic [31:0] m_dir, m_out, m_ie, m_rise, m_fall, m_isr;
    logic [31:0] h [0:2];
    logic        m_ack, m_irq;
    logic [7:0]  m_dat;

    function automatic logic [31:0] m_val(input logic [2:0] r);
        case (r)
            3'd0:    return m_dir;
            3'd1:    return m_out;
            3'd2:    return h[1];
            3'd3:    return m_ie;
            3'd4:    return m_rise;
            3'd5:    return m_fall;
            3'd6:    return m_isr;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic        acc, irq_n;
        logic [31:0] newe, clr, wv, lm;
        int          sh;
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                m_dir = 0; m_out = 0; m_ie = 0; m_rise = 0; m_fall = 0; m_isr = 0;
                h[0] = 0; h[1] = 0; h[2] = 0;
                m_ack = 0; m_irq = 0; m_dat = 0;
            end else begin
                acc   = cyc_i && stb_i && !m_ack;
                newe  = ((h[1] & ~h[2] & m_rise) | (~h[1] & h[2] & m_fall)) & IOMASK;
                irq_n = |(m_isr & m_ie);
                clr   = 0;
                if (acc) begin
                    sh    = 8 * int'(adr_i[1:0]);
                    m_dat = 8'((m_val(adr_i[4:2]) >> sh) & 32'hFF);
                    if (we_i) begin
                        wv = (32'(dat_i) << sh) & IOMASK;
                        lm = (32'hFF << sh) & IOMASK;
                        case (adr_i[4:2])
                            3'd0: m_dir  = (m_dir & ~lm) | wv;
                            3'd1: m_out  = (m_out & ~lm) | wv;
                            3'd3: m_ie   = (m_ie & ~lm) | wv;
                            3'd4: m_rise = (m_rise & ~lm) | wv;
                            3'd5: m_fall = (m_fall & ~lm) | wv;
                            3'd6: clr    = wv;
                            default: ;
                        endcase
                    end
                end
                m_isr = (m_isr & ~clr) | newe;
                m_ack = acc;
                m_irq = irq_n;
                h[2] = h[1];
                h[1] = h[0];
                h[0] = 32'(gpio_i);
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                check("ack", 32'(ack_o), 32'(m_ack));
                check("irq", 32'(irq_o), 32'(m_irq));
                check("gpio_o", 32'(gpio_o), m_out);
                check("gpio_oe", 32'(gpio_oe), m_dir);
                if (m_ack) check("dat_o", 32'(dat_o), 32'(m_dat));
            end
        end
    end

    // ---------------- bus helpers (enter and leave at a falling edge) ----------------
    function automatic logic [4:0] adr_of(input int r, input int b);
        return {3'(r), 2'(b)};
    endfunction

    task automatic wb(input logic we, input logic [4:0] adr, input logic [7:0] d,
                      output logic [7:0] rd);
        cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = d;
        @(negedge clk_i);
        check("ack_hi", 32'(ack_o), 32'd1);
        rd = dat_o;
        cyc_i = 0; stb_i = 0; we_i = 0;
        @(negedge clk_i);
        check("ack_lo", 32'(ack_o), 32'd0);
    endtask

    task automatic wr(input logic [4:0] adr, input logic [7:0] d);
        logic [7:0] x;
        wb(1'b1, adr, d, x);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [7:0] exp);
        logic [7:0] x;
        wb(1'b0, adr, 8'h00, x);
        check(tag, 32'(x), 32'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] x;
        rst_i = 0;
        idle(3);
        rst_i = 1;
        @(negedge clk_i);

        // reset state
        check("oe_rst", 32'(gpio_oe), 32'h0);
        check("irq_rst", 32'(irq_o), 32'h0);
        for (int r = 0; r < 8; r++)
            for (int b = 0; b < 4; b++)
                rd_chk("rst_rd", adr_of(r, b), 8'h00);

        // direction / output, upper lanes ignored
        wr(adr_of(0, 0), 8'hA5);
        wr(adr_of(1, 0), 8'hFF);
        wr(adr_of(1, 1), 8'h3C);
        check("oe_t2", 32'(gpio_oe), 32'h00A5);
        check("o_t2", 32'(gpio_o), 32'h3CFF);
        rd_chk("in_noloop", adr_of(2, 0), 8'h00);
        wr(adr_of(0, 2), 8'hFF);
        wr(adr_of(1, 3), 8'hFF);
        rd_chk("dir_lane2", adr_of(0, 2), 8'h00);
        rd_chk("out_lane3", adr_of(1, 3), 8'h00);
        check("oe_lane2", 32'(gpio_oe), 32'h00A5);

        // rising edge latency on pin 0
        wr(adr_of(3, 0), 8'h01);
        wr(adr_of(4, 0), 8'h01);
        gpio_i[0] = 1'b1;
        @(negedge clk_i); check("irq_k0", 32'(irq_o), 32'd0);
        @(negedge clk_i); check("irq_k1", 32'(irq_o), 32'd0);
        @(negedge clk_i); check("irq_k2", 32'(irq_o), 32'd0);
        @(negedge clk_i); check("irq_k3", 32'(irq_o), 32'd1);
        rd_chk("isr_t3", adr_of(6, 0), 8'h01);
        rd_chk("in_t3", adr_of(2, 0), 8'h01);
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = adr_of(6, 0); dat_i = 8'h01;
        @(negedge clk_i); check("irq_w1c_w", 32'(irq_o), 32'd1);
        cyc_i = 0; stb_i = 0; we_i = 0;
        @(negedge clk_i); check("irq_w1c_w1", 32'(irq_o), 32'd0);

        // both-edge detect on pin 3 while masked, then unmask
        wr(adr_of(5, 0), 8'h08);
        wr(adr_of(4, 0), 8'h09);
        gpio_i[3] = 1'b1; idle(3);
        gpio_i[3] = 1'b0; idle(4);
        rd_chk("isr_t4", adr_of(6, 0), 8'h08);
        check("irq_masked", 32'(irq_o), 32'd0);
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = adr_of(3, 0); dat_i = 8'h09;
        @(negedge clk_i); check("irq_ie_w", 32'(irq_o), 32'd0);
        cyc_i = 0; stb_i = 0; we_i = 0;
        @(negedge clk_i); check("irq_ie_w1", 32'(irq_o), 32'd1);

        // set wins over simultaneous W1C on pin 2
        wr(adr_of(4, 0), 8'h0D);
        gpio_i[2] = 1'b1; idle(4);
        gpio_i[2] = 1'b0; idle(3);
        rd_chk("isr_pre_t5", adr_of(6, 0), 8'h0C);
        gpio_i[2] = 1'b1;
        idle(2);
        wr(adr_of(6, 0), 8'h04);
        rd_chk("isr_t5", adr_of(6, 0), 8'h0C);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_i = IO'($urandom);
            case ($urandom_range(0, 4))
                0: idle($urandom_range(1, 3));
                1, 2: wb(1'b1, 5'($urandom), 8'($urandom), x);
                3: wb(1'b0, 5'($urandom), 8'h00, x);
                default: begin
                    cyc_i = 1; stb_i = 1; we_i = 1'($urandom);
                    adr_i = 5'($urandom); dat_i = 8'($urandom);
                    idle(4);
                    cyc_i = 0; stb_i = 0; we_i = 0;
                    idle(1);
                end
            endcase
        end

        // reset in the middle of an access with every status bit set
        for (int b = 0; b < 2; b++) begin
            wr(adr_of(4, b), 8'hFF);
            wr(adr_of(5, b), 8'hFF);
            wr(adr_of(3, b), 8'hFF);
        end
        wr(adr_of(0, 1), 8'h5A);
        wr(adr_of(1, 1), 8'hC3);
        gpio_i = ~gpio_i;
        idle(4);
        rd_chk("isr_full0", adr_of(6, 0), 8'hFF);
        rd_chk("isr_full1", adr_of(6, 1), 8'hFF);
        check("irq_full", 32'(irq_o), 32'd1);
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = adr_of(0, 0); dat_i = 8'hFF;
        @(posedge clk_i);
        #1 check("ack_pre_rst", 32'(ack_o), 32'd1);
        #1 rst_i = 0;
        #1;
        check("ack_rst", 32'(ack_o), 32'd0);
        check("irq_rst2", 32'(irq_o), 32'd0);
        check("oe_rst2", 32'(gpio_oe), 32'h0);
        check("o_rst2", 32'(gpio_o), 32'h0);
        cyc_i = 0; stb_i = 0; we_i = 0;
        @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        rd_chk("isr_after0", adr_of(6, 0), 8'h00);
        rd_chk("isr_after1", adr_of(6, 1), 8'h00);
        rd_chk("ie_after", adr_of(3, 0), 8'h00);
        rd_chk("dir_after", adr_of(0, 0), 8'h00);
        wr(adr_of(0, 1), 8'h81);
        check("oe_after", 32'(gpio_oe), 32'h8100);
        rd_chk("dir_rb", adr_of(0, 1), 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
